mc_debounce: RTL and testbench

//   Parametrised multi-channel switch/button debouncer for the SoC board I/O.

---
 rtl/mc_debounce.sv | 109 ++++++++++
 tb/tb_mc_debounce.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mc_debounce.sv
// Multi-channel switch/button debouncer: per-channel synchronizer + saturating stability counter.
// Optional `DEBOUNCE_EDGE_EN builds registered rise/fall pulses; otherwise they are tied to 0.
module mc_debounce #(
  parameter int CH           = 8,
  parameter int TICK_DIV     = 1000000,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  if (TICK_DIV < 2 || STABLE_TICKS < 1 || SYNC_STAGES < 2) begin : gBadParams
    $error("mc_debounce: requires TICK_DIV>=2, STABLE_TICKS>=1, SYNC_STAGES>=2");
  end

  logic [PW-1:0]                  presc_q;
  logic                           tick_q;
  logic [CH-1:0][SYNC_STAGES-1:0] syncChain_q;
  logic [CH-1:0]                  syncS;
  logic [CH-1:0][CW-1:0]          stableCnt_q, stableCnt_d;
  logic [CH-1:0]                  db_q, db_d;

  // Shared prescaler; tick is registered so it lands the cycle after the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      tick_q  <= (presc_q == PRESC_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncChain_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        syncChain_q[i] <= {syncChain_q[i][SYNC_STAGES-2:0], sw[i]};
      end
    end
  end

  // A return to the current db level wipes the count, so glitches earn no partial credit.
  always_comb begin
    syncS       = '0;
    stableCnt_d = stableCnt_q;
    db_d        = db_q;
    for (int i = 0; i < CH; i++) begin
      syncS[i] = syncChain_q[i][SYNC_STAGES-1];
      if (syncS[i] == db_q[i]) begin
        stableCnt_d[i] = '0;
      end else if (tick_q) begin
        if (stableCnt_q[i] == CNT_LAST) begin
          db_d[i]        = syncS[i];
          stableCnt_d[i] = '0;
        end else begin
          stableCnt_d[i] = stableCnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stableCnt_q <= '0;
      db_q        <= '0;
    end else begin
      stableCnt_q <= stableCnt_d;
      db_q        <= db_d;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  logic [CH-1:0] rise_q, fall_q;

  // Edge pulses are registered alongside db so they coincide with its first new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

  assign db   = db_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_mc_debounce.sv
// Scoreboard bench for mc_debounce: stimulus pushes expected db/rise/fall events with their cycle,
// a negedge monitor pops them on every db change and also checks the tick cadence.
module tb_mc_debounce;
  localparam int CH           = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int SYNC_STAGES  = 2;
  // Input driven in a cycle with relCyc%4==1: s valid 2 edges later, ticks at +3,+7,+11, db at +12.
  localparam int LAT          = 12;
  // From reset release: s valid at rel 2, ticks at rel 4,8,12, db at rel 13.
  localparam int LAT_RELEASE  = 13;
`ifdef DEBOUNCE_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] db, rise, fall;
  logic          tick;

  typedef struct {
    logic [CH-1:0] db;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    int            cyc;
  } expEvent_t;

  expEvent_t     sbQ[$];
  int            numChecks = 0;
  int            numFails  = 0;
  int            absCyc = 0;
  int            relCyc = 0;
  logic          checking = 1'b0;
  logic [CH-1:0] prevDb = '0;

  mc_debounce #(
    .CH(CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) absCyc <= absCyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) relCyc <= 0;
    else        relCyc <= relCyc + 1;
  end

  // Monitor: tick cadence every cycle, scoreboard pop on every db change, quiet edges otherwise.
  always @(negedge clk) begin
    logic      expTick;
    expEvent_t e;
    if (checking) begin
      expTick = reset && (relCyc != 0) && (relCyc % TICK_DIV == 0);
      numChecks++;
      if (tick !== expTick) begin
        numFails++;
        $display("[TB] FAIL tick rel=%0d: got %b expected %b", relCyc, tick, expTick);
      end
      if (db !== prevDb) begin
        if (sbQ.size() == 0) begin
          numChecks++;
          numFails++;
          $display("[TB] FAIL unexpectedDb cyc=%0d: got %b expected %b", absCyc, db, prevDb);
        end else begin
          e = sbQ.pop_front();
          numChecks += 4;
          if (db !== e.db) begin
            numFails++;
            $display("[TB] FAIL dbValue cyc=%0d: got %b expected %b", absCyc, db, e.db);
          end
          if (absCyc != e.cyc) begin
            numFails++;
            $display("[TB] FAIL dbCycle: got %0d expected %0d", absCyc, e.cyc);
          end
          if (rise !== e.rise) begin
            numFails++;
            $display("[TB] FAIL rise cyc=%0d: got %b expected %b", absCyc, rise, e.rise);
          end
          if (fall !== e.fall) begin
            numFails++;
            $display("[TB] FAIL fall cyc=%0d: got %b expected %b", absCyc, fall, e.fall);
          end
        end
      end else begin
        numChecks++;
        if (rise !== '0 || fall !== '0) begin
          numFails++;
          $display("[TB] FAIL quietEdges cyc=%0d: got rise=%b fall=%b expected 0", absCyc, rise, fall);
        end
      end
      prevDb = db;
    end
  end

  task automatic waitPhase();
    do @(negedge clk); while (relCyc % TICK_DIV != 1);
  endtask

  task automatic applyStimulus(input logic [CH-1:0] newSw, input logic doPush,
                               input logic [CH-1:0] expDb, input logic [CH-1:0] expRise,
                               input logic [CH-1:0] expFall);
    expEvent_t e;
    waitPhase();
    sw = newSw;
    if (doPush) begin
      e.db   = expDb;
      e.rise = EDGE_EN ? expRise : '0;
      e.fall = EDGE_EN ? expFall : '0;
      e.cyc  = absCyc + LAT;
      sbQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expEvent_t e;
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("resetDb", db, '0);
    checkOutput("resetRise", rise, '0);
    checkOutput("resetFall", fall, '0);
    checkOutput("resetTick", {3'b000, tick}, '0);
    checking = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    $display("[TB] idle after reset");
    repeat (40) @(negedge clk);

    $display("[TB] single channel rise");
    applyStimulus(4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000);
    repeat (14) @(negedge clk);

    $display("[TB] glitch on channel 1 then sustained high");
    applyStimulus(4'b0011, 1'b0, '0, '0, '0);
    repeat (8) @(negedge clk);
    sw = 4'b0001;
    repeat (8) @(negedge clk);
    applyStimulus(4'b0011, 1'b1, 4'b0011, 4'b0010, 4'b0000);
    repeat (14) @(negedge clk);

    $display("[TB] simultaneous channel changes");
    applyStimulus(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0011);
    repeat (14) @(negedge clk);
    applyStimulus(4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b0000);
    repeat (14) @(negedge clk);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111);
    repeat (14) @(negedge clk);

    $display("[TB] reset aborts pending count");
    applyStimulus(4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000);
    repeat (14) @(negedge clk);
    applyStimulus(4'b0101, 1'b0, '0, '0, '0);
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    e.db = 4'b0000; e.rise = '0; e.fall = '0; e.cyc = absCyc + 1;
    sbQ.push_back(e);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    e.db = 4'b0101; e.rise = EDGE_EN ? 4'b0101 : 4'b0000; e.fall = '0; e.cyc = absCyc + LAT_RELEASE;
    sbQ.push_back(e);
    repeat (20) @(negedge clk);

    numChecks++;
    if (sbQ.size() != 0) begin
      numFails++;
      $display("[TB] FAIL pendingEvents: got %0d outstanding expected 0", sbQ.size());
    end
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
